ddr3_burst_engine: RTL and testbench
====================================

Name: ddr3_burst_engine

Overview:
- Parametrised successor of the single-FIFO DDR3 user-port controller: moves an arbitrary-length transfer (xfer_len words) between a FWFT streaming source/sink and a MIG-style native port (cmd/wr/rd FIFOs).
- Splits each transfer into bursts of at most MAX_BURST words, tracks the address correctly per burst, and throttles reads against sink space.
- Supports abort at burst boundaries and reports sticky error status. Sits between the Wishbone DDR3 slave's buffers and the memory controller port.

Parameters:
- DATA_WIDTH, 32, port data width; byte mask width = DATA_WIDTH/8.
- ADDR_WIDTH, 28, word address width.
- LEN_WIDTH, 24, transfer length counter width.
- MAX_BURST, 64, max words per command, legal range 1..64.
- ADDR_STEP, 1, address increment per word.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle start pulse; sampled in IDLE only
- dir  in  1  0 = write to memory, 1 = read from memory; sampled with start
- start_addr  in  ADDR_WIDTH  first word address; sampled with start
- xfer_len  in  LEN_WIDTH  words to move; sampled with start
- abort  in  1  request stop at next burst boundary
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at end of transfer
- aborted  out  1  valid with done; transfer ended early
- xfer_count  out  LEN_WIDTH  words completed so far
- status  out  3  sticky: [0] wr_underrun seen, [1] rd_overflow seen, [2] zero-length start
- src_data  in  DATA_WIDTH  write-path source data (FWFT)
- src_valid  in  1  src_data is valid
- src_strobe  out  1  pops source; combinational
- snk_data  out  DATA_WIDTH  read-path data; equals rd_data
- snk_strobe  out  1  pushes snk_data; combinational
- snk_space  in  LEN_WIDTH  free words in sink
- cmd_en  out  1  command strobe
- cmd_instr  out  3  010 = write with precharge, 011 = read with precharge
- cmd_bl  out  6  burst length minus 1
- cmd_word_addr  out  ADDR_WIDTH  command address
- cmd_full  in  1  command FIFO full
- wr_en  out  1  write-data strobe
- wr_mask  out  DATA_WIDTH/8  always 0
- wr_data  out  DATA_WIDTH  write data
- wr_full  in  1  write FIFO full
- wr_underrun  in  1  controller write underrun
- rd_en  out  1  read-data pop; combinational
- rd_data  in  DATA_WIDTH  read data
- rd_empty  in  1  read FIFO empty
- rd_overflow  in  1  read FIFO overflow

Behaviour:
- Reset:
  - Asynchronous; all registered outputs and counters are 0; state = IDLE.
  - Combinational strobes are 0 in IDLE.
- Burst size: chunk = min(remaining, MAX_BURST). chunk is recomputed at each burst start and held for that burst.
- States: IDLE, WR_FILL, WR_CMD, RD_CMD, RD_DRAIN, FINISH.
- IDLE:
  - On start: latch start_addr into cur_addr and xfer_len into remaining; clear status and xfer_count.
  - If xfer_len == 0: set status[2] and go to FINISH.
  - Otherwise go to WR_FILL if dir = 0, else RD_CMD.
  - start is ignored when not in IDLE.
- WR_FILL:
  - src_strobe = src_valid & !wr_full & (fill_cnt < chunk).
  - On the same edge: wr_en <= 1, wr_data <= src_data, fill_cnt increments.
  - When fill_cnt == chunk, go to WR_CMD.
- WR_CMD (when !cmd_full):
  - One-cycle cmd_en with cmd_instr = 010, cmd_bl = chunk-1, cmd_word_addr = cur_addr.
  - Update: cur_addr += chunk*ADDR_STEP; remaining -= chunk; xfer_count += chunk; fill_cnt = 0.
  - Next state: FINISH if remaining == 0 or abort_pend, else WR_FILL.
- RD_CMD:
  - If abort_pend: go to FINISH.
  - Else, when !cmd_full and snk_space >= chunk: issue cmd_en with 011, bl = chunk-1, addr = cur_addr; advance cur_addr; go to RD_DRAIN.
- RD_DRAIN:
  - rd_en = snk_strobe = !rd_empty & (drain_cnt < chunk); each pop increments drain_cnt and xfer_count.
  - When drain_cnt == chunk: remaining -= chunk, drain_cnt = 0, then FINISH if remaining == 0, else RD_CMD.
  - Exactly one read burst is outstanding at a time.
- FINISH:
  - done = 1 for one cycle; aborted = abort_pend; clear abort_pend; go to IDLE.
- Abort:
  - Sets abort_pend while busy; ignored in IDLE.
  - In-flight bursts always complete fully (wr data pushed means the matching command is issued).
- Errors: wr_underrun or rd_overflow high on any cycle while busy sets the matching status bit sticky until the next start. Neither stops the transfer.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Widths: cmd_bl is 6 bits; chunk-1 fits because MAX_BURST <= 64.

Test Plan:
- Write, addr 0x100, len 150, MAX_BURST 64, source always valid -> three commands: bl 63 @0x100, bl 63 @0x140, bl 21 @0x180; 150 wr_en pulses; done with xfer_count 150, aborted 0.
- Read, addr 0x0, len 64, snk_space 10 rising to 64 at cycle 20 -> no cmd_en before cycle 20; single 011 cmd with bl 63; 64 snk_strobes matching rd_data order.
- wr_full and cmd_full toggled pseudo-randomly during a len-100 write -> no data lost or duplicated; src_strobe count = wr_en count = 100; cmd_bl values 63, 35.
- abort pulsed mid-second burst of a len-200 read -> second burst completes; done with aborted 1; xfer_count 128.
- start with len 0 -> done 2 cycles later, status = 100, no cmd_en.
- rst asserted mid WR_FILL -> all outputs 0 immediately (async), busy 0, new start accepted after release; rd_overflow during read -> status[1] set, transfer completes.

Source files
------------

// File: rtl/ddr3_burst_engine.sv
// ddr3_burst_engine
// Moves an xfer_len-word transfer between a FWFT stream (source for writes,
// sink for reads) and a MIG-style native port. Each transfer is split into
// bursts of at most MAX_BURST words. Read commands are only issued when the
// sink can absorb the whole burst. Aborts take effect at burst boundaries.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start/dir/start_addr/xfer_len  transfer request, sampled in IDLE only
//   abort                    stop at the next burst boundary
//   busy/done/aborted        progress; done is a one-cycle pulse
//   xfer_count               words completed so far
//   status                   sticky {zero_len, rd_overflow, wr_underrun}
//   src_*                    write-path FWFT source (src_strobe pops)
//   snk_*                    read-path sink (snk_strobe pushes)
//   cmd_*                    native command port
//   wr_*                     native write-data port (wr_mask fixed at 0)
//   rd_*                     native read-data port (rd_en pops)
module ddr3_burst_engine #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned LEN_WIDTH  = 24,
  parameter int unsigned MAX_BURST  = 64,
  parameter int unsigned ADDR_STEP  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    dir,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [LEN_WIDTH-1:0]    xfer_len,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [LEN_WIDTH-1:0]    xfer_count,
  output logic [2:0]              status,
  input  logic [DATA_WIDTH-1:0]   src_data,
  input  logic                    src_valid,
  output logic                    src_strobe,
  output logic [DATA_WIDTH-1:0]   snk_data,
  output logic                    snk_strobe,
  input  logic [LEN_WIDTH-1:0]    snk_space,
  output logic                    cmd_en,
  output logic [2:0]              cmd_instr,
  output logic [5:0]              cmd_bl,
  output logic [ADDR_WIDTH-1:0]   cmd_word_addr,
  input  logic                    cmd_full,
  output logic                    wr_en,
  output logic [DATA_WIDTH/8-1:0] wr_mask,
  output logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_full,
  input  logic                    wr_underrun,
  output logic                    rd_en,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    rd_empty,
  input  logic                    rd_overflow
);

  typedef enum logic [2:0] {
    IDLE,
    WR_FILL,
    WR_CMD,
    RD_CMD,
    RD_DRAIN,
    FINISH
  } state_t;

  state_t                  state;
  logic [6:0]              chunk;
  logic [6:0]              fill_cnt;
  logic [6:0]              drain_cnt;
  logic [LEN_WIDTH-1:0]    remaining;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic                    abort_pend;

  logic [LEN_WIDTH-1:0]    remaining_after;
  logic [ADDR_WIDTH-1:0]   next_addr;

  function automatic logic [6:0] burst_size(input logic [LEN_WIDTH-1:0] words);
    if (words > LEN_WIDTH'(MAX_BURST))
      return 7'(MAX_BURST);
    return 7'(words);
  endfunction

  assign remaining_after = remaining - LEN_WIDTH'(chunk);
  // Truncation to ADDR_WIDTH gives the modulo-2^ADDR_WIDTH wrap.
  assign next_addr = cur_addr + ADDR_WIDTH'(chunk) * ADDR_WIDTH'(ADDR_STEP);

  assign busy       = (state != IDLE);
  assign src_strobe = (state == WR_FILL) && src_valid && !wr_full && (fill_cnt < chunk);
  assign rd_en      = (state == RD_DRAIN) && !rd_empty && (drain_cnt < chunk);
  assign snk_strobe = rd_en;
  assign snk_data   = rd_data;
  assign wr_mask    = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      chunk         <= '0;
      fill_cnt      <= '0;
      drain_cnt     <= '0;
      remaining     <= '0;
      cur_addr      <= '0;
      abort_pend    <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      xfer_count    <= '0;
      status        <= '0;
      cmd_en        <= 1'b0;
      cmd_instr     <= '0;
      cmd_bl        <= '0;
      cmd_word_addr <= '0;
      wr_en         <= 1'b0;
      wr_data       <= '0;
    end else begin
      cmd_en  <= 1'b0;
      wr_en   <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;

      if (busy && abort)       abort_pend <= 1'b1;
      if (busy && wr_underrun) status[0]  <= 1'b1;
      if (busy && rd_overflow) status[1]  <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            cur_addr   <= start_addr;
            remaining  <= xfer_len;
            chunk      <= burst_size(xfer_len);
            xfer_count <= '0;
            fill_cnt   <= '0;
            drain_cnt  <= '0;
            abort_pend <= 1'b0;
            if (xfer_len == '0) begin
              status <= 3'b100;
              state  <= FINISH;
            end else begin
              status <= '0;
              state  <= dir ? RD_CMD : WR_FILL;
            end
          end
        end

        WR_FILL: begin
          if (src_strobe) begin
            wr_en    <= 1'b1;
            wr_data  <= src_data;
            fill_cnt <= fill_cnt + 7'd1;
          end
          if (fill_cnt == chunk)
            state <= WR_CMD;
        end

        // Data for this burst is already in the write FIFO, so the command
        // is issued even if an abort is pending.
        WR_CMD: begin
          if (!cmd_full) begin
            cmd_en        <= 1'b1;
            cmd_instr     <= 3'b010;
            cmd_bl        <= 6'(chunk - 7'd1);
            cmd_word_addr <= cur_addr;
            cur_addr      <= next_addr;
            remaining     <= remaining_after;
            xfer_count    <= xfer_count + LEN_WIDTH'(chunk);
            fill_cnt      <= '0;
            chunk         <= burst_size(remaining_after);
            state         <= ((remaining_after == '0) || abort_pend) ? FINISH : WR_FILL;
          end
        end

        RD_CMD: begin
          if (abort_pend) begin
            state <= FINISH;
          end else if (!cmd_full && (snk_space >= LEN_WIDTH'(chunk))) begin
            cmd_en        <= 1'b1;
            cmd_instr     <= 3'b011;
            cmd_bl        <= 6'(chunk - 7'd1);
            cmd_word_addr <= cur_addr;
            cur_addr      <= next_addr;
            state         <= RD_DRAIN;
          end
        end

        RD_DRAIN: begin
          if (rd_en) begin
            drain_cnt  <= drain_cnt + 7'd1;
            xfer_count <= xfer_count + LEN_WIDTH'(1);
          end
          if (drain_cnt == chunk) begin
            remaining <= remaining_after;
            drain_cnt <= '0;
            chunk     <= burst_size(remaining_after);
            state     <= (remaining_after == '0) ? FINISH : RD_CMD;
          end
        end

        FINISH: begin
          done       <= 1'b1;
          aborted    <= abort_pend;
          abort_pend <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_burst_engine.sv
// tb_ddr3_burst_engine
// Directed bench for ddr3_burst_engine. Stimulus pushes expected commands,
// write words, sink words and done records into queues; a monitor pops and
// compares them whenever the DUT presents the matching strobe. A small
// source/memory model feeds src_* and rd_* from bench-side queues.
module tb_ddr3_burst_engine;

  localparam int DW = 32;
  localparam int AW = 28;
  localparam int LW = 24;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           dir;
  logic [AW-1:0]  start_addr;
  logic [LW-1:0]  xfer_len;
  logic           abort;
  logic           busy;
  logic           done;
  logic           aborted;
  logic [LW-1:0]  xfer_count;
  logic [2:0]     status;
  logic [DW-1:0]  src_data;
  logic           src_valid;
  logic           src_strobe;
  logic [DW-1:0]  snk_data;
  logic           snk_strobe;
  logic [LW-1:0]  snk_space;
  logic           cmd_en;
  logic [2:0]     cmd_instr;
  logic [5:0]     cmd_bl;
  logic [AW-1:0]  cmd_word_addr;
  logic           cmd_full;
  logic           wr_en;
  logic [DW/8-1:0] wr_mask;
  logic [DW-1:0]  wr_data;
  logic           wr_full;
  logic           wr_underrun;
  logic           rd_en;
  logic [DW-1:0]  rd_data;
  logic           rd_empty;
  logic           rd_overflow;

  ddr3_burst_engine #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LEN_WIDTH(LW),
    .MAX_BURST(64),
    .ADDR_STEP(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .start_addr(start_addr),
    .xfer_len(xfer_len), .abort(abort), .busy(busy), .done(done),
    .aborted(aborted), .xfer_count(xfer_count), .status(status),
    .src_data(src_data), .src_valid(src_valid), .src_strobe(src_strobe),
    .snk_data(snk_data), .snk_strobe(snk_strobe), .snk_space(snk_space),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_word_addr(cmd_word_addr), .cmd_full(cmd_full), .wr_en(wr_en),
    .wr_mask(wr_mask), .wr_data(wr_data), .wr_full(wr_full),
    .wr_underrun(wr_underrun), .rd_en(rd_en), .rd_data(rd_data),
    .rd_empty(rd_empty), .rd_overflow(rd_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    instr;
    logic [5:0]    bl;
    logic [AW-1:0] addr;
  } cmd_t;

  typedef struct {
    logic          ab;
    logic [LW-1:0] cnt;
    logic [2:0]    st;
  } done_t;

  cmd_t          cmdq[$];
  done_t         doneq[$];
  logic [DW-1:0] wrq[$];
  logic [DW-1:0] snkq[$];
  logic [DW-1:0] srcq[$];
  logic [DW-1:0] rdq[$];

  int checks = 0;
  int errors = 0;
  int cmd_cnt = 0;
  int wr_cnt = 0;
  int src_cnt = 0;
  int snk_cnt = 0;
  int done_cnt = 0;
  bit throttle = 1'b0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {4'hD, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT strobe with nothing expected, required no strobe", name);
  endtask

  task automatic add_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [AW-1:0] addr);
    cmd_t c;
    c.instr = instr;
    c.bl    = bl;
    c.addr  = addr;
    cmdq.push_back(c);
  endtask

  task automatic add_done(input logic ab, input logic [LW-1:0] cnt, input logic [2:0] st);
    done_t d;
    d.ab  = ab;
    d.cnt = cnt;
    d.st  = st;
    doneq.push_back(d);
  endtask

  // Source and memory model: samples the DUT strobes at the edge, then
  // updates its queues and drives the FIFO-side inputs 1 unit later.
  always @(posedge clk) begin
    bit            pop_src;
    bit            pop_rd;
    bit            rd_cmd;
    bit            stall;
    logic [5:0]    bl;
    logic [AW-1:0] a;
    pop_src = src_strobe;
    pop_rd  = rd_en;
    rd_cmd  = cmd_en && (cmd_instr == 3'b011);
    bl      = cmd_bl;
    a       = cmd_word_addr;
    #1;
    if (pop_src && srcq.size() > 0) void'(srcq.pop_front());
    if (pop_rd && rdq.size() > 0) void'(rdq.pop_front());
    if (rd_cmd)
      for (int i = 0; i <= int'(bl); i++) rdq.push_back(mem_word(a + AW'(i)));
    if (throttle) begin
      wr_full  = ($urandom_range(0, 2) == 0);
      cmd_full = ($urandom_range(0, 2) == 0);
      stall    = ($urandom_range(0, 3) == 0);
    end else begin
      wr_full  = 1'b0;
      cmd_full = 1'b0;
      stall    = 1'b0;
    end
    src_valid = (srcq.size() > 0);
    src_data  = (srcq.size() > 0) ? srcq[0] : '0;
    rd_empty  = (rdq.size() == 0) || stall;
    rd_data   = (rdq.size() > 0) ? rdq[0] : '0;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    cmd_t          ec;
    done_t         ed;
    logic [DW-1:0] ew;
    if (!rst) begin
      if (src_strobe) src_cnt++;
      if (cmd_en) begin
        cmd_cnt++;
        if (cmdq.size() == 0) unexpected("cmd_en");
        else begin
          ec = cmdq.pop_front();
          check("cmd_instr", 64'(cmd_instr), 64'(ec.instr));
          check("cmd_bl", 64'(cmd_bl), 64'(ec.bl));
          check("cmd_word_addr", 64'(cmd_word_addr), 64'(ec.addr));
        end
      end
      if (wr_en) begin
        wr_cnt++;
        if (wrq.size() == 0) unexpected("wr_en");
        else begin
          ew = wrq.pop_front();
          check("wr_data", 64'(wr_data), 64'(ew));
          check("wr_mask", 64'(wr_mask), 64'd0);
        end
      end
      if (snk_strobe) begin
        snk_cnt++;
        if (snkq.size() == 0) unexpected("snk_strobe");
        else begin
          ew = snkq.pop_front();
          check("snk_data", 64'(snk_data), 64'(ew));
        end
      end
      if (done) begin
        done_cnt++;
        if (doneq.size() == 0) unexpected("done");
        else begin
          ed = doneq.pop_front();
          check("done_aborted", 64'(aborted), 64'(ed.ab));
          check("done_xfer_count", 64'(xfer_count), 64'(ed.cnt));
          check("done_status", 64'(status), 64'(ed.st));
          check("done_busy", 64'(busy), 64'd0);
        end
      end
    end
  end

  task automatic start_xfer(input logic d, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    @(posedge clk);
    #1;
    dir        = d;
    start_addr = addr;
    xfer_len   = len;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int base;
    int n;
    base = done_cnt;
    n    = 0;
    while (done_cnt == base && n < 4000) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == base) begin
      checks++;
      errors++;
      $display("FAIL %s: no done within 4000 cycles, required done pulse", name);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_aborted"}, 64'(aborted), 64'd0);
    check({tag, "_xfer_count"}, 64'(xfer_count), 64'd0);
    check({tag, "_status"}, 64'(status), 64'd0);
    check({tag, "_cmd_en"}, 64'(cmd_en), 64'd0);
    check({tag, "_cmd_bl"}, 64'(cmd_bl), 64'd0);
    check({tag, "_cmd_word_addr"}, 64'(cmd_word_addr), 64'd0);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    check({tag, "_src_strobe"}, 64'(src_strobe), 64'd0);
    check({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    check({tag, "_snk_strobe"}, 64'(snk_strobe), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int b0;
    int b1;
    int b2;
    int n;
    rst         = 1'b1;
    start       = 1'b0;
    dir         = 1'b0;
    start_addr  = '0;
    xfer_len    = '0;
    abort       = 1'b0;
    snk_space   = '0;
    wr_underrun = 1'b0;
    rd_overflow = 1'b0;
    src_valid   = 1'b0;
    src_data    = '0;
    rd_empty    = 1'b1;
    rd_data     = '0;
    wr_full     = 1'b0;
    cmd_full    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // Write 150 words at 0x100: bursts 64, 64, 22.
    for (int i = 0; i < 150; i++) begin
      srcq.push_back(32'hC0DE_0000 + 32'(i));
      wrq.push_back(32'hC0DE_0000 + 32'(i));
    end
    add_cmd(3'b010, 6'd63, 28'h100);
    add_cmd(3'b010, 6'd63, 28'h140);
    add_cmd(3'b010, 6'd21, 28'h180);
    add_done(1'b0, 24'd150, 3'b000);
    b0 = wr_cnt;
    b1 = src_cnt;
    b2 = cmd_cnt;
    start_xfer(1'b0, 28'h100, 24'd150);
    wait_done("t1_done");
    check("t1_wr_en_count", 64'(wr_cnt - b0), 64'd150);
    check("t1_src_strobe_count", 64'(src_cnt - b1), 64'd150);
    check("t1_cmd_count", 64'(cmd_cnt - b2), 64'd3);

    // Read 64 words at 0, sink space too small for 20 cycles.
    snk_space = 24'd10;
    add_cmd(3'b011, 6'd63, 28'h0);
    for (int i = 0; i < 64; i++) snkq.push_back(mem_word(AW'(i)));
    add_done(1'b0, 24'd64, 3'b000);
    b0 = cmd_cnt;
    b1 = snk_cnt;
    start_xfer(1'b1, 28'h0, 24'd64);
    repeat (20) @(posedge clk);
    check("t2_no_cmd_before_space", 64'(cmd_cnt - b0), 64'd0);
    #1 snk_space = 24'd64;
    wait_done("t2_done");
    check("t2_cmd_count", 64'(cmd_cnt - b0), 64'd1);
    check("t2_snk_count", 64'(snk_cnt - b1), 64'd64);

    // Write 100 words under random wr_full / cmd_full back-pressure.
    for (int i = 0; i < 100; i++) begin
      srcq.push_back(32'h3300_0000 + 32'(i));
      wrq.push_back(32'h3300_0000 + 32'(i));
    end
    add_cmd(3'b010, 6'd63, 28'h2000);
    add_cmd(3'b010, 6'd35, 28'h2040);
    add_done(1'b0, 24'd100, 3'b000);
    b0 = wr_cnt;
    b1 = src_cnt;
    b2 = cmd_cnt;
    throttle = 1'b1;
    start_xfer(1'b0, 28'h2000, 24'd100);
    wait_done("t3_done");
    throttle = 1'b0;
    check("t3_wr_en_count", 64'(wr_cnt - b0), 64'd100);
    check("t3_src_strobe_count", 64'(src_cnt - b1), 64'd100);
    check("t3_cmd_count", 64'(cmd_cnt - b2), 64'd2);

    // Read 200 words at 0x300, abort during the second burst.
    snk_space = 24'd200;
    add_cmd(3'b011, 6'd63, 28'h300);
    add_cmd(3'b011, 6'd63, 28'h340);
    for (int i = 0; i < 128; i++) snkq.push_back(mem_word(28'h300 + AW'(i)));
    add_done(1'b1, 24'd128, 3'b000);
    b0 = snk_cnt;
    b2 = cmd_cnt;
    start_xfer(1'b1, 28'h300, 24'd200);
    n = 0;
    while ((snk_cnt - b0) < 80 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_done("t4_done");
    check("t4_snk_count", 64'(snk_cnt - b0), 64'd128);
    check("t4_cmd_count", 64'(cmd_cnt - b2), 64'd2);

    // Zero-length start.
    add_done(1'b0, 24'd0, 3'b100);
    b2 = cmd_cnt;
    start_xfer(1'b0, 28'h777, 24'd0);
    @(posedge clk);
    #1;
    check("t5_done_pulse", 64'(done), 64'd1);
    check("t5_status", 64'(status), 64'd4);
    repeat (2) @(posedge clk);
    check("t5_no_cmd", 64'(cmd_cnt - b2), 64'd0);

    // Reset in the middle of a write fill.
    for (int i = 0; i < 50; i++) begin
      srcq.push_back(32'h6600_0000 + 32'(i));
      wrq.push_back(32'h6600_0000 + 32'(i));
    end
    start_xfer(1'b0, 28'h500, 24'd50);
    repeat (10) @(posedge clk);
    #1;
    check("t6_busy_in_fill", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("t6_async_reset");
    srcq.delete();
    wrq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Read after reset with an rd_overflow pulse.
    snk_space = 24'd64;
    add_cmd(3'b011, 6'd19, 28'h40);
    for (int i = 0; i < 20; i++) snkq.push_back(mem_word(28'h40 + AW'(i)));
    add_done(1'b0, 24'd20, 3'b010);
    b0 = snk_cnt;
    start_xfer(1'b1, 28'h40, 24'd20);
    @(posedge clk);
    #1 rd_overflow = 1'b1;
    @(posedge clk);
    #1 rd_overflow = 1'b0;
    wait_done("t6_done");
    check("t6_snk_count", 64'(snk_cnt - b0), 64'd20);

    repeat (3) @(posedge clk);
    check("end_cmdq_empty", 64'(cmdq.size()), 64'd0);
    check("end_wrq_empty", 64'(wrq.size()), 64'd0);
    check("end_snkq_empty", 64'(snkq.size()), 64'd0);
    check("end_doneq_empty", 64'(doneq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
